// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: word-wide data-memory bus with req/gnt/rvalid handshake.
//   req    master->slave  access request, held until gnt
//   we     master->slave  1 = write, 0 = read (valid while req = 1)
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  read data valid this cycle
//   rdata  slave->master  read data
interface mem_access_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V memory stage, issues word loads/stores and loads MEM/WB.
//   clk, reset_n            clock, asynchronous active-low reset
//   PIP_*_i                 EX/MEM pipeline registers (held stable while stall_o = 1)
//   dmem                    data-memory bus (master side)
//   stall_o                 hold EX/MEM next cycle
//   PIP_write_reg_o/rd_o/wb_data_o  MEM/WB pipeline registers
//   bus_error_o             sticky timeout flag, cleared only by reset
module mem_access_stage #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      PIP_write_mem_i,
   input  logic                      PIP_read_mem_i,
   input  logic [31:0]               PIP_alu_result_i,
   input  logic [31:0]               PIP_second_operand_i,
   input  logic                      PIP_use_mem_i,
   input  logic                      PIP_write_reg_i,
   input  logic [4:0]                PIP_rd_i,
   mem_access_stage_if.master        dmem,
   output logic                      stall_o,
   output logic                      PIP_write_reg_o,
   output logic [4:0]                PIP_rd_o,
   output logic [31:0]               PIP_wb_data_o,
   output logic                      bus_error_o
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       access, is_write, timeout, rd_done, wr_done, bubble;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   // A timed-out access returns to IDLE; otherwise a granted read waits for
   // rvalid and a granted write finishes immediately.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !access ? IDLE : !dmem.gnt ? REQ : is_write ? IDLE : WAIT_R;
         REQ:     state_nxt = timeout ? IDLE : !dmem.gnt ? REQ : is_write ? IDLE : WAIT_R;
         WAIT_R:  state_nxt = (dmem.rvalid || timeout) ? IDLE : WAIT_R;
         default: state_nxt = IDLE;
      endcase
   end
   // Bus request and stall are gated by reset_n so they drop the moment
   // reset asserts, even while EX/MEM still presents an access.
   always_comb begin
      access     = PIP_read_mem_i | PIP_write_mem_i;
      is_write   = PIP_write_mem_i & ~PIP_read_mem_i;
      timeout    = state != IDLE && wait_cnt == LAST && !(state == REQ ? dmem.gnt : dmem.rvalid);
      rd_done    = state == WAIT_R && dmem.rvalid;
      wr_done    = is_write && dmem.gnt && (state == REQ || (state == IDLE && access));
      dmem.req   = reset_n && ((state == IDLE && access) || state == REQ);
      dmem.we    = is_write;
      dmem.addr  = {PIP_alu_result_i[31:2], 2'b00};
      dmem.wdata = PIP_second_operand_i;
      stall_o    = reset_n && (access || state != IDLE) && !rd_done && !wr_done && !timeout;
      bubble     = stall_o || timeout;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt        <= '0;
         PIP_write_reg_o <= 1'b0;
         PIP_rd_o        <= '0;
         PIP_wb_data_o   <= '0;
         bus_error_o     <= 1'b0;
      end else begin
         wait_cnt        <= state == IDLE ? 8'd0 : wait_cnt + 8'd1;
         PIP_write_reg_o <= !bubble && PIP_write_reg_i;
         PIP_rd_o        <= bubble ? 5'd0 : PIP_rd_i;
         if (!bubble) PIP_wb_data_o <= (PIP_use_mem_i && rd_done) ? dmem.rdata : PIP_alu_result_i;
         if (timeout) bus_error_o <= 1'b1;
      end
   end
endmodule
